// File: rtl/t_state_sequencer.sv
// ---------------------------------------------------------------------------
// t_state_sequencer
//
// Generates the one-hot T-state strobes that pace one instruction cycle.
// There are two states, RUN and HALTED. Halt requests take effect at the next
// instruction boundary. A boundary is either the last T-state or an early clr.
// The sequencer also counts retired instructions.
//
// Ports:
//   clk        sole clock, all state updates on posedge
//   reset      synchronous active-high reset (state RUN, T held at zero)
//   clr        end the current instruction early (next T-state is T0)
//   hlt        halt request, taken at the next instruction boundary
//   resume     leave HALTED and start a new instruction at T0
//   step_mode  every instruction boundary enters HALTED
//   wait_req   stall, hold the current T-state (overrides clr)
//   T          registered one-hot T-state strobe, zero when halted or in reset
//   t_count    current T-state index
//   halted     high while in HALTED
//   instr_end  combinational, high in the cycle a boundary is taken
//   instr_cnt  completed instructions, modulo 2^INSTR_W
// ---------------------------------------------------------------------------
module t_state_sequencer #(
    parameter int unsigned NUM_T   = 8,
    parameter int unsigned INSTR_W = 16,
    localparam int unsigned CNT_W  = (NUM_T < 2) ? 1 : $clog2(NUM_T)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               hlt,
    input  logic               resume,
    input  logic               step_mode,
    input  logic               wait_req,
    output logic [NUM_T-1:0]   T,
    output logic [CNT_W-1:0]   t_count,
    output logic               halted,
    output logic               instr_end,
    output logic [INSTR_W-1:0] instr_cnt
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    localparam logic [NUM_T-1:0] T_FIRST = NUM_T'(1);
    localparam logic [CNT_W-1:0] T_LAST  = CNT_W'(NUM_T - 1);

    logic [0:0]         state_q, state_d;
    logic [NUM_T-1:0]   t_q, t_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [INSTR_W-1:0] icnt_q, icnt_d;
    logic               pend_q, pend_d;
    logic               running;
    logic               boundary;

    // After reset, T stays zero for one cycle in RUN before T0 is strobed.
    // Only a cycle with a live strobe may advance or end an instruction.
    assign running  = (state_q == ST_RUN) && (t_q != '0);
    assign boundary = running && !wait_req && (clr || (cnt_q == T_LAST));

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        cnt_d     = cnt_q;
        icnt_d    = icnt_q;
        pend_d    = pend_q;
        instr_end = 1'b0;

        if (state_q == ST_RUN) begin
            pend_d = pend_q | hlt;
            if (!running) begin
                // Post-reset bubble: strobe T0 next cycle.
                t_d   = T_FIRST;
                cnt_d = '0;
            end else if (boundary) begin
                instr_end = !reset;
                icnt_d    = icnt_q + 1'b1;
                cnt_d     = '0;
                pend_d    = 1'b0;
                if (pend_q || hlt || step_mode) begin
                    state_d = ST_HALTED;
                    t_d     = '0;
                end else begin
                    t_d = T_FIRST;
                end
            end else if (!wait_req) begin
                cnt_d = cnt_q + 1'b1;
                t_d   = t_q << 1;
            end
        end else begin
            // hlt wins over resume while halted.
            if (resume && !hlt) begin
                state_d = ST_RUN;
                t_d     = T_FIRST;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            t_q     <= '0;
            cnt_q   <= '0;
            icnt_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
            icnt_q  <= icnt_d;
            pend_q  <= pend_d;
        end
    end

    assign T         = t_q;
    assign t_count   = cnt_q;
    assign halted    = (state_q == ST_HALTED);
    assign instr_cnt = icnt_q;

endmodule
